// File: rtl/riscv_lsu_pkg.sv
// Shared types and helpers for the load-store unit: size codes, state
// encoding, byte-enable masks and store-lane helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_width_e;

  // Undefined codes (3, 6, 7) fall through to word access.
  function automatic lsu_width_e size_width(input logic [2:0] size);
    case (size)
      LDST_B, LDST_BU: return SZ_B;
      LDST_H, LDST_HU: return SZ_H;
      default:         return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] off);
    case (size_width(size))
      SZ_B:    return BE_B << off;
      SZ_H:    return off[1] ? (BE_H << 2) : BE_H;
      default: return BE_W;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] size, input logic [31:0] d);
    case (size_width(size))
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size_width(size))
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_load_extend.sv
// Lane select plus sign/zero extension of a 32-bit read word for loads.
module lsu_load_extend
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sext     = (size_i == LDST_B) || (size_i == LDST_H);
    case (size_width(size_i))
      SZ_B:    result_o = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_H:    result_o = {{16{sext & half_sel[15]}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: request/grant/response bus transaction with core stall.
// Optional misaligned-access trap enabled by LSU_MISALIGN_EXC_EN.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic [DATA_W-1:0] lsu_data_o,
  output logic              lsu_stall_req_o,
  output logic              misalign_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  output lsu_state_e        state_dbg_o
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              we_q, we_d;
  logic [ADDR_W-3:0] waddr_q, waddr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] lsu_data_q, lsu_data_d;
  logic              mis_q, mis_d;
  logic              mis_access;
  logic [DATA_W-1:0] ld_ext;

`ifdef LSU_MISALIGN_EXC_EN
  assign mis_access = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
`else
  assign mis_access = 1'b0;
`endif

  lsu_load_extend u_load_extend (
    .rdata_i  (data_rdata_i),
    .offset_i (off_q),
    .size_i   (size_q),
    .result_o (ld_ext)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      size_q     <= LDST_B;
      off_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      lsu_data_q <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      off_q      <= off_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      lsu_data_q <= lsu_data_d;
      mis_q      <= mis_d;
    end
  end

  // Bus handshake: data_req_o stays high with stable addr/be/wdata/we until
  // data_gnt_i; each granted request is closed by exactly one data_rvalid_i.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    off_d        = off_q;
    we_d         = we_q;
    waddr_d      = waddr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    lsu_data_d   = lsu_data_q;
    mis_d        = 1'b0;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i && arstn_i) begin
          size_d  = lsu_size_i;
          off_d   = lsu_addr_i[1:0];
          we_d    = lsu_we_i;
          waddr_d = lsu_addr_i[ADDR_W-1:2];
          be_d    = byte_enable(lsu_size_i, lsu_addr_i[1:0]);
          wdata_d = store_wdata(lsu_size_i, lsu_data_i);
          if (mis_access) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            data_req_o   = 1'b1;
            data_we_o    = lsu_we_i;
            data_be_o    = be_d;
            data_addr_o  = {lsu_addr_i[ADDR_W-1:2], 2'b00};
            data_wdata_o = wdata_d;
            state_d      = data_gnt_i ? RESP : REQ;
          end
        end
      end
      REQ: begin
        data_req_o   = 1'b1;
        data_we_o    = we_q;
        data_be_o    = be_q;
        data_addr_o  = {waddr_q, 2'b00};
        data_wdata_o = wdata_q;
        if (data_gnt_i) state_d = RESP;
      end
      RESP: begin
        if (data_rvalid_i) begin
          if (!we_q) lsu_data_d = ld_ext;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lsu_stall_req_o = lsu_req_i & (state_q != DONE);
  assign lsu_data_o      = lsu_data_q;
  assign misalign_o      = mis_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed and randomized load/store transactions against an arithmetic
// reference model of lane selection, extension and byte enables.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o, misalign_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;
  lsu_state_e  state_dbg_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_data;

  riscv_lsu dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_data_o(lsu_data_o), .lsu_stall_req_o(lsu_stall_req_o),
    .misalign_o(misalign_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .state_dbg_o(state_dbg_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic int ref_nbytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int ref_lane(input logic [2:0] size, input logic [1:0] off);
    int o;
    o = int'(off);
    return o - (o % ref_nbytes(size));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [1:0] off, input logic [31:0] rd);
    int nb;
    longint unsigned m, v;
    nb = ref_nbytes(size);
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = (longint'(rd) >> (8 * ref_lane(size, off))) & m;
    if ((size == 3'd0 || size == 3'd1) && v > (m >> 1)) v = v + ~m;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] b;
    b = 4'((1 << ref_nbytes(size)) - 1);
    return b << ref_lane(size, off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    int nb;
    nb = ref_nbytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic bit ref_mis(input logic [2:0] size, input logic [1:0] off);
`ifdef LSU_MISALIGN_EXC_EN
    return (int'(off) % ref_nbytes(size)) != 0;
`else
    return (size == 3'd7) && (off == 2'd3) && (size != 3'd7);
`endif
  endfunction

  // driver: one memory instruction, bus answering gnt after gd cycles and rvalid rd cycles later
  task automatic do_access(input string tag, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gd, input int rd, input logic [31:0] rdat);
    bit mis, in_req, in_resp, in_done;
    int last;
    lsu_state_e exp_st;
    mis = ref_mis(size, addr[1:0]);
    if (!we && !mis) exp_q.push_back(ref_load(size, addr[1:0], rdat));
    else exp_q.push_back(model_data);
    last = mis ? 1 : gd + rd + 1;
    for (int c = 0; c <= last; c++) begin
      in_req  = !mis && (c <= gd);
      in_resp = !mis && (c > gd) && (c <= gd + rd);
      in_done = (c == last);
      @(posedge clk_i); #1;
      lsu_req_i  = 1'b1;
      lsu_we_i   = we;
      lsu_size_i = size;
      lsu_addr_i = addr;
      lsu_data_i = wd;
      data_gnt_i    = in_req ? (c == gd) : 1'($urandom_range(0, 1));
      data_rvalid_i = in_resp ? (c == gd + rd) : 1'($urandom_range(0, 1));
      data_rdata_i  = (in_resp && c == gd + rd) ? rdat : $urandom;
      @(negedge clk_i);
      if (c == 0) exp_st = IDLE;
      else if (in_req) exp_st = REQ;
      else if (in_resp) exp_st = RESP;
      else exp_st = DONE;
      check({tag, ".state"}, 32'(state_dbg_o), 32'(exp_st));
      check({tag, ".req"}, 32'(data_req_o), 32'(in_req));
      check({tag, ".be"}, 32'(data_be_o), in_req ? 32'(ref_be(size, addr[1:0])) : 32'd0);
      if (in_req) begin
        check({tag, ".addr"}, data_addr_o, {addr[31:2], 2'b00});
        check({tag, ".we"}, 32'(data_we_o), 32'(we));
        check({tag, ".wdata"}, data_wdata_o, ref_wdata(size, wd));
      end
      check({tag, ".stall"}, 32'(lsu_stall_req_o), 32'(!in_done));
      check({tag, ".misalign"}, 32'(misalign_o), 32'(mis && in_done));
      if (in_done) model_data = exp_q.pop_front();
      check({tag, ".ldata"}, lsu_data_o, model_data);
    end
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    @(negedge clk_i);
    check({tag, ".idle_state"}, 32'(state_dbg_o), 32'(IDLE));
    check({tag, ".idle_req"}, 32'(data_req_o), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".state"}, 32'(state_dbg_o), 32'(IDLE));
    check({tag, ".ldata"}, lsu_data_o, 32'd0);
    check({tag, ".req"}, 32'(data_req_o), 32'd0);
    check({tag, ".be"}, 32'(data_be_o), 32'd0);
    check({tag, ".misalign"}, 32'(misalign_o), 32'd0);
  endtask

  initial begin
    arstn_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
    lsu_addr_i = '0; lsu_data_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    model_data = '0;
    #12;
    check_reset_state("reset");
    check("reset.stall", 32'(lsu_stall_req_o), 32'd0);
    @(negedge clk_i); arstn_i = 1'b1;

    do_access("lw_basic",  1'b0, 3'd2, 32'h0000_0100, 32'h0,         0, 1, 32'hDEAD_BEEF);
    do_access("lb_neg",    1'b0, 3'd0, 32'h0000_0103, 32'h0,         0, 1, 32'h8012_3456);
    do_access("lbu",       1'b0, 3'd4, 32'h0000_0103, 32'h0,         0, 1, 32'h8012_3456);
    do_access("sh",        1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 0, 1, 32'h0);
    do_access("lw_slow",   1'b0, 3'd2, 32'h0000_0300, 32'h0,         3, 2, 32'hCAFE_F00D);
    do_access("lh_hi",     1'b0, 3'd1, 32'h0000_0012, 32'h0,         1, 1, 32'hF00F_1234);
    do_access("lhu_hi",    1'b0, 3'd5, 32'h0000_0012, 32'h0,         0, 3, 32'hF00F_1234);
    do_access("sb_lane2",  1'b1, 3'd0, 32'h0000_0402, 32'h0000_00A5, 2, 1, 32'h0);
    do_access("lw_mis",    1'b0, 3'd2, 32'h0000_0101, 32'h0,         0, 1, 32'h1357_9BDF);
    do_access("lh_mis",    1'b0, 3'd1, 32'h0000_0203, 32'h0,         1, 1, 32'h8765_4321);
    do_access("code7",     1'b0, 3'd7, 32'h0000_0500, 32'h0,         0, 1, 32'h0BAD_C0DE);

    // asynchronous reset while waiting for the response, then a stray rvalid
    @(posedge clk_i); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2;
    lsu_addr_i = 32'h0000_0600; data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    data_gnt_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid.state_resp", 32'(state_dbg_o), 32'(RESP));
    #1 arstn_i = 1'b0;
    #1;
    check_reset_state("rst_mid");
    model_data = '0;
    exp_q.delete();
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0;
    @(negedge clk_i); arstn_i = 1'b1;
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    check_reset_state("rst_stray");
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_reset_state("rst_after");

    for (int n = 0; n < 60; n++) begin
      do_access($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
